// File: rtl/multicycle_controller.sv
// Sequencing controller for the multicycle ARM32 core: walks each instruction
// through fetch/decode/execute/memory/writeback and owns the NZCV flags.
module multicycle_controller (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] Cond,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic [3:0] Rd,
    input  logic [3:0] ALUFlags,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       MemWrite,
    output logic       RegWrite,
    output logic       IRWrite,
    output logic       AdrSrc,
    output logic [1:0] ResultSrc,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSrc,
    output logic [1:0] RegSrc,
    output logic [1:0] ALUControl,
    output logic [3:0] Flags
);

    typedef enum logic [3:0] {
        FETCH,
        DECODE,
        EXECUTER,
        EXECUTEI,
        ALUWB,
        MEMADR,
        MEMRD,
        MEMWB,
        MEMWR,
        BRANCH
    } state_t;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    state_t     state;
    state_t     next_state;
    logic [3:0] nzcv;
    logic       cond_ex_q;
    logic       cond_ex;

    logic       reg_w;
    logic       mem_w;
    logic       branch;
    logic       fetch_adv;
    logic       alu_op;
    logic [1:0] flag_w;
    logic       pcs;

    logic       flag_n;
    logic       flag_z;
    logic       flag_c;
    logic       flag_v;

    assign flag_n = nzcv[3];
    assign flag_z = nzcv[2];
    assign flag_c = nzcv[1];
    assign flag_v = nzcv[0];

    // Condition evaluation against the architectural flags; 1111 never executes.
    always_comb begin
        cond_ex = 1'b0;
        case (Cond)
            4'b0000: cond_ex = flag_z;
            4'b0001: cond_ex = ~flag_z;
            4'b0010: cond_ex = flag_c;
            4'b0011: cond_ex = ~flag_c;
            4'b0100: cond_ex = flag_n;
            4'b0101: cond_ex = ~flag_n;
            4'b0110: cond_ex = flag_v;
            4'b0111: cond_ex = ~flag_v;
            4'b1000: cond_ex = flag_c & ~flag_z;
            4'b1001: cond_ex = ~flag_c | flag_z;
            4'b1010: cond_ex = (flag_n == flag_v);
            4'b1011: cond_ex = (flag_n != flag_v);
            4'b1100: cond_ex = ~flag_z & (flag_n == flag_v);
            4'b1101: cond_ex = flag_z | (flag_n != flag_v);
            4'b1110: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= FETCH;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        reg_w      = 1'b0;
        mem_w      = 1'b0;
        branch     = 1'b0;
        fetch_adv  = 1'b0;
        alu_op     = 1'b0;
        AdrSrc     = 1'b0;
        ResultSrc  = 2'b00;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        case (state)
            FETCH: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                if (mem_ready) begin
                    fetch_adv  = 1'b1;
                    next_state = DECODE;
                end
            end
            DECODE: begin
                // PC+8 is formed here so R15 reads see the ARM pipeline offset.
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                case (Op)
                    2'b00:   next_state = Funct[5] ? EXECUTEI : EXECUTER;
                    2'b01:   next_state = MEMADR;
                    2'b10:   next_state = BRANCH;
                    default: next_state = FETCH;
                endcase
            end
            EXECUTER: begin
                alu_op     = 1'b1;
                next_state = ALUWB;
            end
            EXECUTEI: begin
                alu_op     = 1'b1;
                ALUSrcB    = 2'b01;
                next_state = ALUWB;
            end
            ALUWB: begin
                reg_w      = 1'b1;
                next_state = FETCH;
            end
            MEMADR: begin
                ALUSrcB    = 2'b01;
                next_state = Funct[0] ? MEMRD : MEMWR;
            end
            MEMRD: begin
                AdrSrc = 1'b1;
                if (mem_ready) begin
                    next_state = MEMWB;
                end
            end
            MEMWB: begin
                ResultSrc  = 2'b01;
                reg_w      = 1'b1;
                next_state = FETCH;
            end
            MEMWR: begin
                AdrSrc = 1'b1;
                mem_w  = 1'b1;
                if (mem_ready) begin
                    next_state = FETCH;
                end
            end
            BRANCH: begin
                ALUSrcB    = 2'b01;
                ResultSrc  = 2'b10;
                branch     = 1'b1;
                next_state = FETCH;
            end
            default: begin
                next_state = FETCH;
            end
        endcase
    end

    // Unrecognised data-processing commands fall back to ADD.
    always_comb begin
        ALUControl = ALU_ADD;
        flag_w     = 2'b00;
        if (alu_op) begin
            case (Funct[4:1])
                4'b0100: ALUControl = ALU_ADD;
                4'b0010: ALUControl = ALU_SUB;
                4'b0000: ALUControl = ALU_AND;
                4'b1100: ALUControl = ALU_ORR;
                default: ALUControl = ALU_ADD;
            endcase
            flag_w[1] = Funct[0];
            flag_w[0] = Funct[0] & ((ALUControl == ALU_ADD) | (ALUControl == ALU_SUB));
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cond_ex_q <= 1'b0;
        end else if (state == DECODE) begin
            cond_ex_q <= cond_ex;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            nzcv <= 4'b0000;
        end else if (alu_op && cond_ex_q) begin
            if (flag_w[1]) begin
                nzcv[3:2] <= ALUFlags[3:2];
            end
            if (flag_w[0]) begin
                nzcv[1:0] <= ALUFlags[1:0];
            end
        end
    end

    // Strobes are masked by reset_n so nothing can commit once reset falls.
    assign pcs      = (reg_w & (Rd == 4'b1111)) | branch;
    assign PCWrite  = reset_n & (fetch_adv | (pcs & cond_ex_q));
    assign MemWrite = reset_n & mem_w & mem_ready & cond_ex_q;
    assign RegWrite = reset_n & reg_w & cond_ex_q;
    assign IRWrite  = reset_n & fetch_adv;

    assign ImmSrc = Op;
    assign RegSrc = {(Op == 2'b01), (Op == 2'b10)};
    assign Flags  = nzcv;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed-vector bench for multicycle_controller: a per-cycle table of
// instruction fields and expected controls, plus reset and flag corner cases.
module tb_multicycle_controller;

    logic       clk;
    logic       reset_n;
    logic [3:0] Cond;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic [3:0] Rd;
    logic [3:0] ALUFlags;
    logic       mem_ready;
    logic       PCWrite;
    logic       MemWrite;
    logic       RegWrite;
    logic       IRWrite;
    logic       AdrSrc;
    logic [1:0] ResultSrc;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ImmSrc;
    logic [1:0] RegSrc;
    logic [1:0] ALUControl;
    logic [3:0] Flags;

    int checks;
    int failures;

    typedef struct {
        logic [3:0] cond;
        logic [1:0] op;
        logic [5:0] funct;
        logic [3:0] rd;
        logic [3:0] alu_flags;
        logic       mr;
        logic [3:0] writes;
        logic       adr;
        logic [1:0] rsrc;
        logic       src_a;
        logic [1:0] src_b;
        logic [1:0] aluc;
        logic [3:0] flags;
    } vec_t;

    vec_t vecs[$];

    multicycle_controller dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .Cond       (Cond),
        .Op         (Op),
        .Funct      (Funct),
        .Rd         (Rd),
        .ALUFlags   (ALUFlags),
        .mem_ready  (mem_ready),
        .PCWrite    (PCWrite),
        .MemWrite   (MemWrite),
        .RegWrite   (RegWrite),
        .IRWrite    (IRWrite),
        .AdrSrc     (AdrSrc),
        .ResultSrc  (ResultSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ImmSrc     (ImmSrc),
        .RegSrc     (RegSrc),
        .ALUControl (ALUControl),
        .Flags      (Flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic [3:0] cond, input logic [1:0] op,
                                input logic [5:0] funct, input logic [3:0] rd,
                                input logic [3:0] af, input logic mr,
                                input logic [3:0] w, input logic adr,
                                input logic [1:0] rs, input logic a,
                                input logic [1:0] b, input logic [1:0] c,
                                input logic [3:0] flg);
        vec_t v;
        v.cond = cond; v.op = op; v.funct = funct; v.rd = rd;
        v.alu_flags = af; v.mr = mr; v.writes = w; v.adr = adr;
        v.rsrc = rs; v.src_a = a; v.src_b = b; v.aluc = c; v.flags = flg;
        return v;
    endfunction

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic apply_stimulus(input logic [3:0] cond, input logic [1:0] op,
                                  input logic [5:0] funct, input logic [3:0] rd,
                                  input logic [3:0] af, input logic mr);
        @(negedge clk);
        Cond = cond; Op = op; Funct = funct; Rd = rd; ALUFlags = af; mem_ready = mr;
        #2;
    endtask

    function automatic logic [31:0] observed();
        return {12'd0, PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ResultSrc,
                ALUSrcA, ALUSrcB, ALUControl, Flags, ImmSrc, RegSrc};
    endfunction

    function automatic logic [31:0] expected_of(input vec_t v);
        logic [1:0] reg_src;
        reg_src = {(v.op == 2'b01), (v.op == 2'b10)};
        return {12'd0, v.writes, v.adr, v.rsrc, v.src_a, v.src_b, v.aluc,
                v.flags, v.op, reg_src};
    endfunction

    initial begin
        checks   = 0;
        failures = 0;

        // writes column is {PCWrite, MemWrite, RegWrite, IRWrite}
        // ADD R1,R2,R3
        vecs.push_back(mk(4'hE, 2'b00, 6'b001000, 4'h1, 4'h0, 1'b1, 4'b1001, 1'b0, 2'b10, 1'b1, 2'b10, 2'b00, 4'b0000));
        vecs.push_back(mk(4'hE, 2'b00, 6'b001000, 4'h1, 4'h0, 1'b1, 4'b0000, 1'b0, 2'b10, 1'b1, 2'b10, 2'b00, 4'b0000));
        vecs.push_back(mk(4'hE, 2'b00, 6'b001000, 4'h1, 4'h0, 1'b1, 4'b0000, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00, 4'b0000));
        vecs.push_back(mk(4'hE, 2'b00, 6'b001000, 4'h1, 4'h0, 1'b1, 4'b0010, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00, 4'b0000));
        // SUBS with ALU flags Z=1
        vecs.push_back(mk(4'hE, 2'b00, 6'b000101, 4'h2, 4'b0100, 1'b1, 4'b1001, 1'b0, 2'b10, 1'b1, 2'b10, 2'b00, 4'b0000));
        vecs.push_back(mk(4'hE, 2'b00, 6'b000101, 4'h2, 4'b0100, 1'b1, 4'b0000, 1'b0, 2'b10, 1'b1, 2'b10, 2'b00, 4'b0000));
        vecs.push_back(mk(4'hE, 2'b00, 6'b000101, 4'h2, 4'b0100, 1'b1, 4'b0000, 1'b0, 2'b00, 1'b0, 2'b00, 2'b01, 4'b0000));
        vecs.push_back(mk(4'hE, 2'b00, 6'b000101, 4'h2, 4'b0100, 1'b1, 4'b0010, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00, 4'b0100));
        // BEQ taken
        vecs.push_back(mk(4'h0, 2'b10, 6'b100000, 4'h0, 4'h0, 1'b1, 4'b1001, 1'b0, 2'b10, 1'b1, 2'b10, 2'b00, 4'b0100));
        vecs.push_back(mk(4'h0, 2'b10, 6'b100000, 4'h0, 4'h0, 1'b1, 4'b0000, 1'b0, 2'b10, 1'b1, 2'b10, 2'b00, 4'b0100));
        vecs.push_back(mk(4'h0, 2'b10, 6'b100000, 4'h0, 4'h0, 1'b1, 4'b1000, 1'b0, 2'b10, 1'b0, 2'b01, 2'b00, 4'b0100));
        // BNE not taken
        vecs.push_back(mk(4'h1, 2'b10, 6'b100000, 4'h0, 4'h0, 1'b1, 4'b1001, 1'b0, 2'b10, 1'b1, 2'b10, 2'b00, 4'b0100));
        vecs.push_back(mk(4'h1, 2'b10, 6'b100000, 4'h0, 4'h0, 1'b1, 4'b0000, 1'b0, 2'b10, 1'b1, 2'b10, 2'b00, 4'b0100));
        vecs.push_back(mk(4'h1, 2'b10, 6'b100000, 4'h0, 4'h0, 1'b1, 4'b0000, 1'b0, 2'b10, 1'b0, 2'b01, 2'b00, 4'b0100));
        // LDR with two wait cycles in MEMRD
        vecs.push_back(mk(4'hE, 2'b01, 6'b011001, 4'h3, 4'h0, 1'b1, 4'b1001, 1'b0, 2'b10, 1'b1, 2'b10, 2'b00, 4'b0100));
        vecs.push_back(mk(4'hE, 2'b01, 6'b011001, 4'h3, 4'h0, 1'b1, 4'b0000, 1'b0, 2'b10, 1'b1, 2'b10, 2'b00, 4'b0100));
        vecs.push_back(mk(4'hE, 2'b01, 6'b011001, 4'h3, 4'h0, 1'b1, 4'b0000, 1'b0, 2'b00, 1'b0, 2'b01, 2'b00, 4'b0100));
        vecs.push_back(mk(4'hE, 2'b01, 6'b011001, 4'h3, 4'h0, 1'b0, 4'b0000, 1'b1, 2'b00, 1'b0, 2'b00, 2'b00, 4'b0100));
        vecs.push_back(mk(4'hE, 2'b01, 6'b011001, 4'h3, 4'h0, 1'b0, 4'b0000, 1'b1, 2'b00, 1'b0, 2'b00, 2'b00, 4'b0100));
        vecs.push_back(mk(4'hE, 2'b01, 6'b011001, 4'h3, 4'h0, 1'b1, 4'b0000, 1'b1, 2'b00, 1'b0, 2'b00, 2'b00, 4'b0100));
        vecs.push_back(mk(4'hE, 2'b01, 6'b011001, 4'h3, 4'h0, 1'b1, 4'b0010, 1'b0, 2'b01, 1'b0, 2'b00, 2'b00, 4'b0100));
        // STR with mem_ready 0,0,1 in MEMWR
        vecs.push_back(mk(4'hE, 2'b01, 6'b011000, 4'h4, 4'h0, 1'b1, 4'b1001, 1'b0, 2'b10, 1'b1, 2'b10, 2'b00, 4'b0100));
        vecs.push_back(mk(4'hE, 2'b01, 6'b011000, 4'h4, 4'h0, 1'b1, 4'b0000, 1'b0, 2'b10, 1'b1, 2'b10, 2'b00, 4'b0100));
        vecs.push_back(mk(4'hE, 2'b01, 6'b011000, 4'h4, 4'h0, 1'b1, 4'b0000, 1'b0, 2'b00, 1'b0, 2'b01, 2'b00, 4'b0100));
        vecs.push_back(mk(4'hE, 2'b01, 6'b011000, 4'h4, 4'h0, 1'b0, 4'b0000, 1'b1, 2'b00, 1'b0, 2'b00, 2'b00, 4'b0100));
        vecs.push_back(mk(4'hE, 2'b01, 6'b011000, 4'h4, 4'h0, 1'b0, 4'b0000, 1'b1, 2'b00, 1'b0, 2'b00, 2'b00, 4'b0100));
        vecs.push_back(mk(4'hE, 2'b01, 6'b011000, 4'h4, 4'h0, 1'b1, 4'b0100, 1'b1, 2'b00, 1'b0, 2'b00, 2'b00, 4'b0100));
        // ADD to R15
        vecs.push_back(mk(4'hE, 2'b00, 6'b001000, 4'hF, 4'h0, 1'b1, 4'b1001, 1'b0, 2'b10, 1'b1, 2'b10, 2'b00, 4'b0100));
        vecs.push_back(mk(4'hE, 2'b00, 6'b001000, 4'hF, 4'h0, 1'b1, 4'b0000, 1'b0, 2'b10, 1'b1, 2'b10, 2'b00, 4'b0100));
        vecs.push_back(mk(4'hE, 2'b00, 6'b001000, 4'hF, 4'h0, 1'b1, 4'b0000, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00, 4'b0100));
        vecs.push_back(mk(4'hE, 2'b00, 6'b001000, 4'hF, 4'h0, 1'b1, 4'b1010, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00, 4'b0100));
        // ADDS loads all four flags
        vecs.push_back(mk(4'hE, 2'b00, 6'b001001, 4'h5, 4'b0011, 1'b1, 4'b1001, 1'b0, 2'b10, 1'b1, 2'b10, 2'b00, 4'b0100));
        vecs.push_back(mk(4'hE, 2'b00, 6'b001001, 4'h5, 4'b0011, 1'b1, 4'b0000, 1'b0, 2'b10, 1'b1, 2'b10, 2'b00, 4'b0100));
        vecs.push_back(mk(4'hE, 2'b00, 6'b001001, 4'h5, 4'b0011, 1'b1, 4'b0000, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00, 4'b0100));
        vecs.push_back(mk(4'hE, 2'b00, 6'b001001, 4'h5, 4'b0011, 1'b1, 4'b0010, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00, 4'b0011));
        // ANDS updates N,Z only; C,V stay 1
        vecs.push_back(mk(4'hE, 2'b00, 6'b000001, 4'h6, 4'b1100, 1'b1, 4'b1001, 1'b0, 2'b10, 1'b1, 2'b10, 2'b00, 4'b0011));
        vecs.push_back(mk(4'hE, 2'b00, 6'b000001, 4'h6, 4'b1100, 1'b1, 4'b0000, 1'b0, 2'b10, 1'b1, 2'b10, 2'b00, 4'b0011));
        vecs.push_back(mk(4'hE, 2'b00, 6'b000001, 4'h6, 4'b1100, 1'b1, 4'b0000, 1'b0, 2'b00, 1'b0, 2'b00, 2'b10, 4'b0011));
        vecs.push_back(mk(4'hE, 2'b00, 6'b000001, 4'h6, 4'b1100, 1'b1, 4'b0010, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00, 4'b1111));
        // ORR immediate, no S
        vecs.push_back(mk(4'hE, 2'b00, 6'b111000, 4'h7, 4'h0, 1'b1, 4'b1001, 1'b0, 2'b10, 1'b1, 2'b10, 2'b00, 4'b1111));
        vecs.push_back(mk(4'hE, 2'b00, 6'b111000, 4'h7, 4'h0, 1'b1, 4'b0000, 1'b0, 2'b10, 1'b1, 2'b10, 2'b00, 4'b1111));
        vecs.push_back(mk(4'hE, 2'b00, 6'b111000, 4'h7, 4'h0, 1'b1, 4'b0000, 1'b0, 2'b00, 1'b0, 2'b01, 2'b11, 4'b1111));
        vecs.push_back(mk(4'hE, 2'b00, 6'b111000, 4'h7, 4'h0, 1'b1, 4'b0010, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00, 4'b1111));
        // Op=11 no-op
        vecs.push_back(mk(4'hE, 2'b11, 6'b000000, 4'h0, 4'h0, 1'b1, 4'b1001, 1'b0, 2'b10, 1'b1, 2'b10, 2'b00, 4'b1111));
        vecs.push_back(mk(4'hE, 2'b11, 6'b000000, 4'h0, 4'h0, 1'b1, 4'b0000, 1'b0, 2'b10, 1'b1, 2'b10, 2'b00, 4'b1111));
        // Cond=1111 ADDS to R15: walks the states, writes nothing
        vecs.push_back(mk(4'hF, 2'b00, 6'b001001, 4'hF, 4'h0, 1'b1, 4'b1001, 1'b0, 2'b10, 1'b1, 2'b10, 2'b00, 4'b1111));
        vecs.push_back(mk(4'hF, 2'b00, 6'b001001, 4'hF, 4'h0, 1'b1, 4'b0000, 1'b0, 2'b10, 1'b1, 2'b10, 2'b00, 4'b1111));
        vecs.push_back(mk(4'hF, 2'b00, 6'b001001, 4'hF, 4'h0, 1'b1, 4'b0000, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00, 4'b1111));
        vecs.push_back(mk(4'hF, 2'b00, 6'b001001, 4'hF, 4'h0, 1'b1, 4'b0000, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00, 4'b1111));
        // Fetch stall then no-op
        vecs.push_back(mk(4'hE, 2'b11, 6'b000000, 4'h0, 4'h0, 1'b0, 4'b0000, 1'b0, 2'b10, 1'b1, 2'b10, 2'b00, 4'b1111));
        vecs.push_back(mk(4'hE, 2'b11, 6'b000000, 4'h0, 4'h0, 1'b1, 4'b1001, 1'b0, 2'b10, 1'b1, 2'b10, 2'b00, 4'b1111));
        vecs.push_back(mk(4'hE, 2'b11, 6'b000000, 4'h0, 4'h0, 1'b1, 4'b0000, 1'b0, 2'b10, 1'b1, 2'b10, 2'b00, 4'b1111));

        reset_n   = 1'b0;
        Cond      = 4'hE;
        Op        = 2'b00;
        Funct     = 6'b001000;
        Rd        = 4'h1;
        ALUFlags  = 4'h0;
        mem_ready = 1'b1;
        #2;
        // In reset: strobes forced low, FETCH selects, NZCV clear
        check_output("reset_state", observed(),
                     {12'd0, 4'b0000, 1'b0, 2'b10, 1'b1, 2'b10, 2'b00, 4'b0000, 2'b00, 2'b00});

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            if (i == 0) reset_n = 1'b1;
            Cond = vecs[i].cond; Op = vecs[i].op; Funct = vecs[i].funct;
            Rd = vecs[i].rd; ALUFlags = vecs[i].alu_flags; mem_ready = vecs[i].mr;
            #2;
            check_output($sformatf("row%0d", i), observed(), expected_of(vecs[i]));
        end

        // Reset asserted in the MEMWR completion cycle of a STR
        apply_stimulus(4'hE, 2'b01, 6'b011000, 4'h4, 4'h0, 1'b1);
        apply_stimulus(4'hE, 2'b01, 6'b011000, 4'h4, 4'h0, 1'b1);
        apply_stimulus(4'hE, 2'b01, 6'b011000, 4'h4, 4'h0, 1'b1);
        apply_stimulus(4'hE, 2'b01, 6'b011000, 4'h4, 4'h0, 1'b1);
        check_output("memwr_before_reset", {30'd0, MemWrite, AdrSrc}, 32'd3);
        #1;
        reset_n = 1'b0;
        #1;
        check_output("memwr_reset_strobes", {28'd0, PCWrite, MemWrite, RegWrite, IRWrite}, 32'd0);
        check_output("reset_fetch_selects", {26'd0, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc}, 32'b011010);
        check_output("reset_nzcv", {28'd0, Flags}, 32'd0);

        // ANDS after release: from NZCV=0000 with ALUFlags=1011 -> 1000
        @(negedge clk);
        reset_n = 1'b1;
        Cond = 4'hE; Op = 2'b00; Funct = 6'b000001; Rd = 4'h1; ALUFlags = 4'b1011; mem_ready = 1'b1;
        #2;
        check_output("post_reset_fetch", {30'd0, IRWrite, PCWrite}, 32'd3);
        apply_stimulus(4'hE, 2'b00, 6'b000001, 4'h1, 4'b1011, 1'b1);
        check_output("post_reset_decode", {28'd0, PCWrite, MemWrite, RegWrite, IRWrite}, 32'd0);
        apply_stimulus(4'hE, 2'b00, 6'b000001, 4'h1, 4'b1011, 1'b1);
        check_output("ands_alucontrol", {30'd0, ALUControl}, 32'd2);
        apply_stimulus(4'hE, 2'b00, 6'b000001, 4'h1, 4'b1011, 1'b1);
        check_output("ands_flags", {28'd0, Flags}, 32'b1000);
        check_output("ands_writeback", {28'd0, PCWrite, MemWrite, RegWrite, IRWrite}, 32'b0010);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
